// File: rtl/sni_uart.sv
// sni_uart: 8N1 byte UART between the top-level pins and the SNI command block.
// RX deserialises into rdata_m and signals each byte with a 2-cycle rxint pulse.
// TX serialises the byte strobed in with tdata_i and holds txint high while busy.
// RTS follows the SNI rx-buffer-full flag. CTS can optionally gate the start of a tx frame.
module sni_uart #(
    parameter int DIV     = 186,
    parameter bit USE_CTS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    output logic        txd,
    input  logic        cts_n,
    output logic        rts_n,
    input  logic        rbf,
    input  logic        tdata_i,
    input  logic [15:0] tdata_m,
    output logic        txint,
    output logic        rxint,
    output logic [15:0] rdata_m
);

    localparam logic [15:0] BIT_T  = 16'(DIV);
    localparam logic [15:0] HALF_T = 16'(DIV / 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic        rxd_s1_q, rxd_s2_q, rxd_prev_q, cts_s1_q, cts_s2_q, rts_n_q;
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        ovr_q, ovr_d;
    logic [15:0] rdata_q, rdata_d;
    logic [1:0]  rxint_cnt_q, rxint_cnt_d;
    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d, tx_nidx;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        txd_q, txd_d, txint_q, txint_d;
    logic        cts_ok;
    logic        unused_tdata_hi;

    assign unused_tdata_hi = ^tdata_m[15:8];
    assign cts_ok          = (USE_CTS == 1'b0) || !cts_s2_q;
    assign tx_nidx         = tx_idx_q + 3'd1;

    assign txd     = txd_q;
    assign txint   = txint_q;
    assign rxint   = (rxint_cnt_q != 2'd0);
    assign rdata_m = rdata_q;
    assign rts_n   = rts_n_q;

    // RX FSM: detect start edge, sample mid-bit, deliver or drop at the stop sample
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_idx_d    = rx_idx_q;
        rx_sh_d     = rx_sh_q;
        ovr_d       = ovr_q;
        rdata_d     = rdata_q;
        rxint_cnt_d = (rxint_cnt_q != 2'd0) ? rxint_cnt_q - 2'd1 : 2'd0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rxd_prev_q && !rxd_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_T;
                end
            end
            RX_START: begin
                if (rx_cnt_q == 16'd1) begin
                    if (!rxd_s2_q) begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = BIT_T;
                        rx_idx_d   = 3'd0;
                    end else begin
                        rx_state_d = RX_IDLE;   // start bit vanished: treat as a glitch
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == 16'd1) begin
                    rx_sh_d  = {rxd_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = BIT_T;
                    rx_idx_d = rx_idx_q + 3'd1;   // wraps 7->0 on the way to STOP
                    if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == 16'd1) begin
                    rx_state_d = RX_IDLE;
                    if (rbf) begin
                        ovr_d = 1'b1;   // sni cannot take it: drop and remember
                    end else begin
                        rdata_d     = {6'b0, ovr_q, ~rxd_s2_q, rx_sh_q};
                        ovr_d       = 1'b0;
                        rxint_cnt_d = 2'd2;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // TX FSM: latch byte, wait for CTS, then shift start/data/stop with txd registered
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
        txd_d      = txd_q;
        txint_d    = txint_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tdata_i) begin
                    tx_sh_d = tdata_m[7:0];
                    txint_d = 1'b1;
                    // CTS already granted: zero-length WAIT so txint spans exactly 10 bits
                    if (cts_ok) begin
                        tx_state_d = TX_START;
                        tx_cnt_d   = BIT_T;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = TX_WAIT;
                    end
                end
            end
            TX_WAIT: begin
                if (cts_ok) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = BIT_T;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == 16'd1) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = BIT_T;
                    tx_idx_d   = 3'd0;
                    txd_d      = tx_sh_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == 16'd1) begin
                    tx_cnt_d = BIT_T;
                    tx_idx_d = tx_nidx;
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        txd_d = tx_sh_q[tx_nidx];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == 16'd1) begin
                    tx_state_d = TX_IDLE;
                    txint_d    = 1'b0;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // State registers, input synchronisers and RTS
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_s1_q    <= 1'b1;
            rxd_s2_q    <= 1'b1;
            rxd_prev_q  <= 1'b1;
            cts_s1_q    <= 1'b1;
            cts_s2_q    <= 1'b1;
            rts_n_q     <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= 16'd0;
            rx_idx_q    <= 3'd0;
            rx_sh_q     <= 8'd0;
            ovr_q       <= 1'b0;
            rdata_q     <= 16'd0;
            rxint_cnt_q <= 2'd0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= 16'd0;
            tx_idx_q    <= 3'd0;
            tx_sh_q     <= 8'd0;
            txd_q       <= 1'b1;
            txint_q     <= 1'b0;
        end else begin
            rxd_s1_q    <= rxd;
            rxd_s2_q    <= rxd_s1_q;
            rxd_prev_q  <= rxd_s2_q;
            cts_s1_q    <= cts_n;
            cts_s2_q    <= cts_s1_q;
            rts_n_q     <= rbf;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_idx_q    <= rx_idx_d;
            rx_sh_q     <= rx_sh_d;
            ovr_q       <= ovr_d;
            rdata_q     <= rdata_d;
            rxint_cnt_q <= rxint_cnt_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_idx_q    <= tx_idx_d;
            tx_sh_q     <= tx_sh_d;
            txd_q       <= txd_d;
            txint_q     <= txint_d;
        end
    end

endmodule

// File: tb/tb_sni_uart.sv
// tb_sni_uart: directed + randomized bench for sni_uart (DIV=8).
// dut gates TX on CTS; dut2 has CTS gating disabled.
module tb_sni_uart;
    localparam int DIV = 8;

    logic        clk = 1'b0, reset = 1'b1;
    logic        rxd = 1'b1, cts_n = 1'b1, rbf = 1'b0, tdata_i = 1'b0;
    logic [15:0] tdata_m = 16'd0;
    logic        txd, rts_n, txint, rxint;
    logic [15:0] rdata_m;
    logic        rxd2 = 1'b1, cts_n2 = 1'b1, rbf2 = 1'b0, tdata_i2 = 1'b0;
    logic [15:0] tdata_m2 = 16'd0;
    logic        txd2, rts_n2, txint2, rxint2;
    logic [15:0] rdata_m2;

    int n_vec = 0, n_err = 0;

    sni_uart #(.DIV(DIV), .USE_CTS(1'b1)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .txd(txd), .cts_n(cts_n), .rts_n(rts_n),
        .rbf(rbf), .tdata_i(tdata_i), .tdata_m(tdata_m), .txint(txint), .rxint(rxint),
        .rdata_m(rdata_m));

    sni_uart #(.DIV(DIV), .USE_CTS(1'b0)) dut2 (
        .clk(clk), .reset(reset), .rxd(rxd2), .txd(txd2), .cts_n(cts_n2), .rts_n(rts_n2),
        .rbf(rbf2), .tdata_i(tdata_i2), .tdata_m(tdata_m2), .txint(txint2), .rxint(rxint2),
        .rdata_m(rdata_m2));

    always #5 clk = ~clk;

    // rxint pulse monitor: counts rising edges and measures each pulse length
    int   pulses = 0, run = 0, last_len = 0;
    logic prev_rxint = 1'b0;
    always @(negedge clk) begin
        if (rxint && !prev_rxint) pulses++;
        if (rxint) run++;
        else begin
            if (prev_rxint) last_len = run;
            run = 0;
        end
        prev_rxint = rxint;
    end

    // Reference model of the receive side: what sni should see per frame
    logic        model_ovr   = 1'b0;
    logic [15:0] model_rdata = 16'd0;
    function automatic void model_rx(input logic [7:0] b, input logic stop, input logic busy,
                                     output int exp_p, output logic [15:0] exp_d);
        if (busy) begin
            model_ovr = 1'b1;
            exp_p     = 0;
        end else begin
            model_rdata = {6'd0, model_ovr, ~stop, b};
            model_ovr   = 1'b0;
            exp_p       = 1;
        end
        exp_d = model_rdata;
    endfunction

    // Drive one 8N1 frame on rxd, idle, then report what the DUT produced
    task automatic rx_send(input logic [7:0] b, input logic stop,
                           output int np, output logic [15:0] d, output int len);
        int p0;
        logic [9:0] fr;
        p0 = pulses;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        np  = pulses - p0;
        d   = rdata_m;
        len = last_len;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({txd, rts_n, txint, rxint} !== 4'b1100 || rdata_m !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state: txd/rts_n/txint/rxint=%b rdata=%h, want 1100 0000",
                     {txd, rts_n, txint, rxint}, rdata_m);
        end
        reset = 1'b0;
        cts_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (rts_n !== 1'b0) begin
            n_err++;
            $display("FAIL rts_follow_rbf0: rts_n=%b want 0", rts_n);
        end
    endtask

    task automatic rx_case(input string nm, input logic [7:0] b, input logic stop, input logic busy);
        int np, len, ep;
        logic [15:0] d, ed;
        rbf = busy;
        repeat (2) @(negedge clk);
        n_vec++;
        if (rts_n !== busy) begin
            n_err++;
            $display("FAIL %s_rts: rts_n=%b want %b", nm, rts_n, busy);
        end
        rx_send(b, stop, np, d, len);
        model_rx(b, stop, busy, ep, ed);
        n_vec++;
        if (np !== ep || d !== ed) begin
            n_err++;
            $display("FAIL %s: pulses=%0d rdata=%h, want pulses=%0d rdata=%h", nm, np, d, ep, ed);
        end
        if (ep == 1) begin
            n_vec++;
            if (len !== 2) begin
                n_err++;
                $display("FAIL %s_pulse_len: %0d want 2", nm, len);
            end
        end
        rbf = 1'b0;
    endtask

    task automatic test_loopback();
        rx_case("loopback_a5", 8'hA5, 1'b1, 1'b0);
        n_vec++;
        if (rdata_m !== 16'h00A5) begin
            n_err++;
            $display("FAIL loopback_lit: rdata=%h want 00a5", rdata_m);
        end
    endtask

    task automatic test_frame_error();
        rx_case("frame_err_3c", 8'h3C, 1'b0, 1'b0);
        rx_case("after_ferr_11", 8'h11, 1'b1, 1'b0);
    endtask

    task automatic test_overrun();
        rx_case("overrun_drop_55", 8'h55, 1'b1, 1'b1);
        rx_case("overrun_flag_66", 8'h66, 1'b1, 1'b0);
        n_vec++;
        if (rdata_m !== 16'h0266) begin
            n_err++;
            $display("FAIL overrun_lit: rdata=%h want 0266", rdata_m);
        end
    endtask

    task automatic test_random_rx();
        for (int i = 0; i < 10; i++)
            rx_case("rand_rx", 8'($urandom), ($urandom_range(0, 4) != 0),
                    ($urandom_range(0, 3) == 0));
    endtask

    // Each frame also strobes mid-frame and in the txint-falling cycle; both must be ignored
    task automatic test_tx();
        logic [7:0] b;
        logic [9:0] fr;
        logic       ed, ei;
        int         hi;
        for (int f = 0; f < 5; f++) begin
            b  = (f == 0) ? 8'h81 : 8'($urandom);
            fr = {1'b1, b, 1'b0};
            hi = 0;
            @(negedge clk);
            tdata_i = 1'b1;
            tdata_m = {8'($urandom), b};
            for (int k = 0; k <= 10 * DIV + 2; k++) begin
                @(negedge clk);
                ei = (k < 10 * DIV);
                ed = ei ? fr[k / DIV] : 1'b1;
                n_vec++;
                if (txd !== ed || txint !== ei) begin
                    n_err++;
                    $display("FAIL tx_bit byte=%h k=%0d: txd=%b txint=%b want txd=%b txint=%b",
                             b, k, txd, txint, ed, ei);
                end
                if (txint) hi++;
                tdata_i = (k == 40) || (k == 10 * DIV - 1);
                tdata_m = 16'($urandom);
            end
            n_vec++;
            if (hi !== 10 * DIV) begin
                n_err++;
                $display("FAIL tx_txint_len byte=%h: %0d want %0d", b, hi, 10 * DIV);
            end
        end
    endtask

    task automatic test_cts();
        int lat, n;
        cts_n = 1'b1;
        repeat (4) @(negedge clk);
        tdata_i = 1'b1;
        tdata_m = 16'h0042;
        @(negedge clk);
        tdata_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_vec++;
            if (txd !== 1'b1 || txint !== 1'b1) begin
                n_err++;
                $display("FAIL cts_hold: txd=%b txint=%b want 1 1", txd, txint);
            end
        end
        cts_n = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (txd !== 1'b0 && lat < 12);
        n_vec++;
        if (lat > 3) begin
            n_err++;
            $display("FAIL cts_release_latency: %0d cycles want <=3", lat);
        end
        cts_n = 1'b1;   // withdrawing CTS after START must not pause the frame
        n = 0;
        while (txint === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n !== 10 * DIV) begin
            n_err++;
            $display("FAIL cts_no_pause: frame took %0d cycles want %0d", n, 10 * DIV);
        end
        cts_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_no_cts();
        @(negedge clk);
        tdata_i2 = 1'b1;
        tdata_m2 = 16'h0042;
        @(negedge clk);
        tdata_i2 = 1'b0;
        n_vec++;
        if (txd2 !== 1'b0 || txint2 !== 1'b1) begin
            n_err++;
            $display("FAIL nocts_start: txd=%b txint=%b want 0 1", txd2, txint2);
        end
        repeat (10 * DIV) @(negedge clk);
        n_vec++;
        if (txint2 !== 1'b0 || txd2 !== 1'b1 || rxint2 !== 1'b0 || rdata_m2 !== 16'd0) begin
            n_err++;
            $display("FAIL nocts_end: txint=%b txd=%b rxint=%b rdata=%h want 0 1 0 0000",
                     txint2, txd2, rxint2, rdata_m2);
        end
    endtask

    task automatic test_glitch_reset();
        int p0, seen_tx;
        logic [9:0] fr;
        p0 = pulses;
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        n_vec++;
        if (pulses - p0 !== 0 || rdata_m !== model_rdata) begin
            n_err++;
            $display("FAIL glitch: pulses=%0d rdata=%h want 0 %h", pulses - p0, rdata_m, model_rdata);
        end
        // abort an RX and a TX frame part-way
        fr = {1'b1, 8'hC3, 1'b0};
        for (int c = 0; c < 4 * DIV; c++) begin
            rxd     = fr[c / DIV];
            tdata_i = (c == 0);
            tdata_m = 16'h00F0;
            @(negedge clk);
        end
        tdata_i = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        rxd = 1'b1;
        n_vec++;
        if ({txd, txint, rxint} !== 3'b100 || rdata_m !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid: txd/txint/rxint=%b rdata=%h want 100 0000",
                     {txd, txint, rxint}, rdata_m);
        end
        @(negedge clk);
        reset       = 1'b0;
        model_ovr   = 1'b0;
        model_rdata = 16'd0;
        p0 = pulses;
        seen_tx = 0;
        for (int c = 0; c < 12 * DIV; c++) begin
            @(negedge clk);
            if (txint !== 1'b0 || txd !== 1'b1) seen_tx++;
        end
        n_vec++;
        if (pulses - p0 !== 0 || seen_tx !== 0) begin
            n_err++;
            $display("FAIL after_reset_quiet: rx pulses=%0d tx activity=%0d want 0 0",
                     pulses - p0, seen_tx);
        end
        rx_case("after_reset_5a", 8'h5A, 1'b1, 1'b0);
    endtask

    // RX and TX running on top of each other
    task automatic test_concurrent();
        logic [7:0]  rb, tb;
        logic [9:0]  fr;
        int          np, len, ep;
        logic [15:0] d, ed;
        rb = 8'($urandom);
        tb = 8'($urandom);
        fr = {1'b1, tb, 1'b0};
        @(negedge clk);
        fork
            rx_send(rb, 1'b1, np, d, len);
            begin
                tdata_i = 1'b1;
                tdata_m = {8'h00, tb};
                for (int k = 0; k < 10 * DIV; k++) begin
                    @(negedge clk);
                    tdata_i = 1'b0;
                    n_vec++;
                    if (txd !== fr[k / DIV] || txint !== 1'b1) begin
                        n_err++;
                        $display("FAIL concurrent_tx k=%0d: txd=%b txint=%b want %b 1",
                                 k, txd, txint, fr[k / DIV]);
                    end
                end
            end
        join
        model_rx(rb, 1'b1, 1'b0, ep, ed);
        n_vec++;
        if (np !== ep || d !== ed || txint !== 1'b0) begin
            n_err++;
            $display("FAIL concurrent_rx: pulses=%0d rdata=%h txint=%b want %0d %h 0",
                     np, d, txint, ep, ed);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_frame_error();
        test_overrun();
        test_random_rx();
        test_tx();
        test_cts();
        test_no_cts();
        test_glitch_reset();
        test_concurrent();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
